// File: rtl/bkm_steps_ctrl.sv
// Sequencing controller for an iterative BKM step datapath: accepts an operand
// pair, runs one LOAD cycle plus N_STEPS-1 ITER cycles, then holds the result.
module bkm_steps_ctrl #(
  parameter int WD      = 64,
  parameter int N_STEPS = 64,
  parameter int WN      = 7
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          enable,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WD-1:0] in_X,
  input  logic [WD-1:0] in_Y,
  output logic [WD-1:0] op_X,
  output logic [WD-1:0] op_Y,
  output logic          step_load,
  output logic          step_en,
  output logic [WN-1:0] step_n,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  localparam logic [WN-1:0] LAST = WN'(N_STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [WN-1:0] r_cnt;
  logic [WN-1:0] w_cnt_nxt;
  logic          w_accept;
  logic [WD-1:0] r_op_x;
  logic [WD-1:0] r_op_y;
  logic          r_out_valid;
  logic          r_busy;
  logic [WN-1:0] r_step_n;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_ITER;
        w_cnt_nxt   = WN'(1);
      end
      S_ITER: begin
        if (r_cnt == LAST) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + WN'(1);
        end
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op_x      <= '0;
      r_op_y      <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_step_n    <= '0;
    end else if (enable) begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_step_n    <= (w_state_nxt == S_ITER) ? w_cnt_nxt : '0;
      if (w_accept) begin
        r_op_x <= in_X;
        r_op_y <= in_Y;
      end
    end
  end

  assign in_ready  = enable && (r_state == S_IDLE);
  assign step_load = enable && (r_state == S_LOAD);
  assign step_en   = enable && ((r_state == S_LOAD) || (r_state == S_ITER));
  assign step_n    = r_step_n;
  assign op_X      = r_op_x;
  assign op_Y      = r_op_y;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_bkm_steps_ctrl.sv
// Directed bench for bkm_steps_ctrl: N_STEPS=4 instance with a result
// scoreboard, plus an N_STEPS=2 instance for the shortest sequence.
module tb_bkm_steps_ctrl;
  localparam int WD = 16;
  localparam int N  = 4;
  localparam int WN = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srst, enable, in_valid, out_ready;
  logic [WD-1:0] in_X, in_Y, op_X, op_Y;
  logic          in_ready, step_load, step_en, out_valid, busy;
  logic [WN-1:0] step_n;

  logic          b_in_valid, b_out_ready;
  logic [WD-1:0] b_in_X, b_in_Y, b_op_X, b_op_Y;
  logic          b_in_ready, b_step_load, b_step_en, b_out_valid, b_busy;
  logic [WN-1:0] b_step_n;

  bkm_steps_ctrl #(.WD(WD), .N_STEPS(N), .WN(WN)) dut (
    .clk(clk), .srst(srst), .enable(enable), .in_valid(in_valid),
    .in_ready(in_ready), .in_X(in_X), .in_Y(in_Y), .op_X(op_X), .op_Y(op_Y),
    .step_load(step_load), .step_en(step_en), .step_n(step_n),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  bkm_steps_ctrl #(.WD(WD), .N_STEPS(2), .WN(WN)) dut2 (
    .clk(clk), .srst(srst), .enable(enable), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_X(b_in_X), .in_Y(b_in_Y), .op_X(b_op_X),
    .op_Y(b_op_Y), .step_load(b_step_load), .step_en(b_step_en),
    .step_n(b_step_n), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .busy(b_busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WD-1:0] x;
    logic [WD-1:0] y;
    int            t0;
    int            lat;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic ov_q = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result monitor: on every rising out_valid, pop and compare the oldest expectation.
  always @(negedge clk) begin
    if (out_valid && !ov_q) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("res_op_X", op_X, e.x);
        chk("res_op_Y", op_Y, e.y);
        chk("res_latency", cyc - e.t0, e.lat);
      end
    end
    ov_q = out_valid;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic [WD-1:0] x, input logic [WD-1:0] y, input int extra);
    exp_t n;
    in_valid = 1'b1;
    in_X     = x;
    in_Y     = y;
    n.x = x; n.y = y; n.t0 = cyc; n.lat = N + 1 + extra;
    sb.push_back(n);
    tick();
    in_valid = 1'b0;
    in_X     = 16'hDEAD;
    in_Y     = 16'hBEEF;
  endtask

  task automatic finish_op();
    for (int i = 0; i < 50 && !out_valid; i++) tick();
    chk("wait_out_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("handoff_idle_busy", busy, 0);
  endtask

  int last_acc;

  initial begin
    srst = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_X = '0; in_Y = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_X = '0; b_in_Y = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_step_n", step_n, 0);
    chk("rst_step_en", step_en, 0);
    chk("rst_op_X", op_X, 0);
    chk("rst_op_Y", op_Y, 0);
    srst = 1'b0;
    tick();

    // Basic sequence and long DONE hold
    chk("idle_in_ready", in_ready, 1);
    issue(16'd5, 16'd9, 0);
    chk("load_step_load", step_load, 1);
    chk("load_step_en", step_en, 1);
    chk("load_step_n", step_n, 0);
    chk("load_busy", busy, 1);
    chk("load_in_ready", in_ready, 0);
    chk("load_op_X", op_X, 5);
    chk("load_op_Y", op_Y, 9);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("iter_step_n", step_n, k);
      chk("iter_step_load", step_load, 0);
      chk("iter_step_en", step_en, 1);
    end
    tick();
    chk("done_out_valid", out_valid, 1);
    chk("done_step_en", step_en, 0);
    chk("done_step_n", step_n, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("back_idle_out_valid", out_valid, 0);
    chk("back_idle_in_ready", in_ready, 1);
    chk("back_idle_busy", busy, 0);

    // Enable stall for three edges at step_n=2
    issue(16'h1234, 16'h4321, 3);
    tick(); tick();
    chk("pre_stall_step_n", step_n, 2);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_step_en", step_en, 0);
      chk("stall_step_load", step_load, 0);
      chk("stall_step_n", step_n, 2);
      chk("stall_busy", busy, 1);
    end
    enable = 1'b1;
    tick();
    chk("post_stall_step_n", step_n, 3);
    finish_op();

    // Mid-operation reset aborts
    issue(16'd7, 16'd8, 0);
    tick(); tick();
    chk("pre_rst_step_n", step_n, 2);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    sb.delete();
    chk("abort_busy", busy, 0);
    chk("abort_step_n", step_n, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_op_X", op_X, 0);
    chk("abort_in_ready", in_ready, 1);
    for (int k = 0; k < 6; k++) tick();
    issue(16'h0077, 16'h0088, 0);
    chk("restart_step_load", step_load, 1);
    finish_op();

    // Back-to-back accepts with in_valid and out_ready held high
    tick();
    in_valid = 1'b1; in_X = 16'h3C3C; in_Y = 16'hC3C3; out_ready = 1'b1;
    last_acc = -1;
    for (int k = 0; k < 3 * (N + 2) + 1; k++) begin
      chk("ready_while_busy", in_ready && busy, 0);
      if (in_ready) begin
        exp_t n;
        if (last_acc >= 0) chk("accept_spacing", cyc - last_acc, N + 2);
        last_acc = cyc;
        n.x = in_X; n.y = in_Y; n.t0 = cyc; n.lat = N + 1;
        sb.push_back(n);
      end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 50 && busy; i++) tick();
    chk("drain_busy", busy, 0);
    out_ready = 1'b0;
    tick(); tick();

    // N_STEPS=2 boundary
    chk("n2_in_ready", b_in_ready, 1);
    b_in_valid = 1'b1; b_in_X = 16'd3; b_in_Y = 16'd4;
    tick();
    b_in_valid = 1'b0;
    chk("n2_load_step_load", b_step_load, 1);
    chk("n2_load_step_n", b_step_n, 0);
    chk("n2_op_X", b_op_X, 3);
    chk("n2_op_Y", b_op_Y, 4);
    tick();
    chk("n2_iter_step_n", b_step_n, 1);
    chk("n2_iter_step_load", b_step_load, 0);
    chk("n2_iter_step_en", b_step_en, 1);
    chk("n2_iter_out_valid", b_out_valid, 0);
    tick();
    chk("n2_done_out_valid", b_out_valid, 1);
    chk("n2_done_step_en", b_step_en, 0);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    chk("n2_idle_in_ready", b_in_ready, 1);
    chk("n2_idle_out_valid", b_out_valid, 0);
    chk("n2_idle_busy", b_busy, 0);

    tick(); tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
